// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Formats, error codes and a signed-range helper used by the immediate checks.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_BADFMT   = 2'd3
  } enc_err_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // True when imm[31:lsb] are all equal, i.e. the value sign-extends from bit lsb.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned lsb);
    logic signed [31:0] s;
    s = $signed(imm) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Push when full and pop when empty are ignored.
module enc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields and a 32-bit immediate into machine words, checks the
// immediate, tags good words with a running word address and queues them.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_fmt,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_addr_start,
  input  logic              i_err_clr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]       instr_enc;
  enc_err_e          err_next;
  enc_err_e          err_code;
  logic [ADDR_W-1:0] addr_cnt;
  logic              accept;
  logic              push;
  logic              reject;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  always_comb begin
    instr_enc = '0;
    err_next  = ERR_NONE;
    case (fmt_e'(i_fmt))
      FMT_R: instr_enc = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        instr_enc = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (!fits_signed(i_imm, 11)) err_next = ERR_RANGE;
      end
      FMT_S: begin
        instr_enc = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        if (!fits_signed(i_imm, 11)) err_next = ERR_RANGE;
      end
      FMT_B: begin
        instr_enc = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], i_opcode};
        if (i_imm[0])                     err_next = ERR_MISALIGN;
        else if (!fits_signed(i_imm, 12)) err_next = ERR_RANGE;
      end
      FMT_U: begin
        instr_enc = {i_imm[31:12], i_rd, i_opcode};
        if (i_imm[11:0] != '0) err_next = ERR_MISALIGN;
      end
      FMT_J: begin
        instr_enc = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        if (i_imm[0])                     err_next = ERR_MISALIGN;
        else if (!fits_signed(i_imm, 20)) err_next = ERR_RANGE;
      end
      default: err_next = ERR_BADFMT;
    endcase
  end

  // Rejected bundles are still handshaken so the producer never stalls on them.
  assign o_ready = (fifo_count < CW'(DEPTH));
  assign accept  = i_valid && o_ready;
  assign push    = accept && (err_next == ERR_NONE);
  assign reject  = accept && (err_next != ERR_NONE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_cnt <= '0;
      o_err    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (i_addr_load) addr_cnt <= i_addr_start;
      else if (push)   addr_cnt <= addr_cnt + 1'b1;
      o_err <= reject;
      if (reject)         err_code <= err_next;
      else if (i_err_clr) err_code <= ERR_NONE;
    end
  end

  assign o_err_code = err_code;
  assign o_valid    = !fifo_empty;

  enc_fifo #(
    .WIDTH (32 + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .din   ({instr_enc, addr_cnt}),
    .pop   (o_valid && i_ready),
    .dout  ({o_instr, o_addr}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, rejects, backpressure,
// address load/wrap and asynchronous reset, with hand-computed expectations.
module tb_instr_encoder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_fmt;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;
  logic        i_addr_load;
  logic [7:0]  i_addr_start;
  logic        i_err_clr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [7:0]  o_addr;
  logic        o_err;
  logic [1:0]  o_err_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_fmt(i_fmt), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .i_addr_load(i_addr_load), .i_addr_start(i_addr_start), .i_err_clr(i_err_clr),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_addr(o_addr),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    i_fmt = fmt; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int k = 0;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    i_valid = 1'b1;
    while (!o_ready && k < 20) begin
      @(posedge i_clk); #1; k++;
    end
    if (!o_ready) check("ready_timeout", {31'b0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic addi(input logic [4:0] rd, input logic [31:0] imm);
    send(3'd1, 7'h13, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_addr_load = 1'b0; i_addr_start = '0; i_err_clr = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_addr", {24'b0, o_addr}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_code", {30'b0, o_err_code}, 32'd0);
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // Format encodings
    addi(5'd1, 32'd5);
    check("addi_valid", {31'b0, o_valid}, 32'd1);
    check("addi_instr", o_instr, 32'h00500093);
    check("addi_addr", {24'b0, o_addr}, 32'd0);
    pop_one();
    check("pop_empty", {31'b0, o_valid}, 32'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    check("lui_instr", o_instr, 32'h123452B7);
    check("lui_addr", {24'b0, o_addr}, 32'd1);
    pop_one();
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    check("beq_instr", o_instr, 32'hFE208EE3);
    check("beq_addr", {24'b0, o_addr}, 32'd2);
    pop_one();
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    check("jal_instr", o_instr, 32'h001000EF);
    check("jal_addr", {24'b0, o_addr}, 32'd3);
    pop_one();
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFFFF8);
    check("sw_instr", o_instr, 32'hFE312C23);
    check("sw_addr", {24'b0, o_addr}, 32'd4);
    pop_one();
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF);
    check("add_instr", o_instr, 32'h002081B3);
    check("add_addr", {24'b0, o_addr}, 32'd5);
    pop_one();

    // Rejects
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    check("bmis_err", {31'b0, o_err}, 32'd1);
    check("bmis_code", {30'b0, o_err_code}, 32'd2);
    check("bmis_nopush", {31'b0, o_valid}, 32'd0);
    @(posedge i_clk); #1;
    check("bmis_pulse1", {31'b0, o_err}, 32'd0);
    check("bmis_sticky", {30'b0, o_err_code}, 32'd2);
    addi(5'd1, 32'd2048);
    check("irange_code", {30'b0, o_err_code}, 32'd1);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    check("umis_code", {30'b0, o_err_code}, 32'd2);
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    check("badfmt_code", {30'b0, o_err_code}, 32'd3);
    i_err_clr = 1'b1;
    @(posedge i_clk); #1;
    i_err_clr = 1'b0;
    check("errclr_code", {30'b0, o_err_code}, 32'd0);
    i_err_clr = 1'b1;
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    i_err_clr = 1'b0;
    check("clr_vs_rej", {30'b0, o_err_code}, 32'd3);
    addi(5'd1, 32'hFFFFF800);
    check("imin_err", {31'b0, o_err}, 32'd0);
    check("imin_instr", o_instr, 32'h80000093);
    check("imin_addr", {24'b0, o_addr}, 32'd6);
    pop_one();

    // Backpressure and simultaneous push/pop
    addi(5'd1, 32'd1);
    addi(5'd2, 32'd2);
    addi(5'd3, 32'd3);
    addi(5'd4, 32'd4);
    check("full_ready", {31'b0, o_ready}, 32'd0);
    check("full_head", {24'b0, o_addr}, 32'd7);
    check("full_instr", o_instr, 32'h00100093);
    drive(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b0;
    check("fullpop_head", {24'b0, o_addr}, 32'd8);
    check("fullpop_ready", {31'b0, o_ready}, 32'd1);
    pop_one();
    check("pop2_head", {24'b0, o_addr}, 32'd9);
    i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b0;
    check("pp_head", {24'b0, o_addr}, 32'd10);
    check("pp_instr", o_instr, 32'h00400213);
    pop_one();
    check("fifth_addr", {24'b0, o_addr}, 32'd11);
    check("fifth_instr", o_instr, 32'h00500293);
    pop_one();
    check("drain_empty", {31'b0, o_valid}, 32'd0);

    // Address load with same-cycle bundle, then wrap
    i_addr_start = 8'hFF; i_addr_load = 1'b1;
    addi(5'd1, 32'd1);
    i_addr_load = 1'b0;
    addi(5'd2, 32'd2);
    addi(5'd3, 32'd3);
    addi(5'd4, 32'd4);
    check("load_old", {24'b0, o_addr}, 32'h0C);
    pop_one();
    check("load_ff", {24'b0, o_addr}, 32'hFF);
    pop_one();
    check("load_wrap", {24'b0, o_addr}, 32'h00);
    pop_one();
    check("load_next", {24'b0, o_addr}, 32'h01);
    check("load_instr", o_instr, 32'h00400213);
    pop_one();

    // Reset mid-operation
    addi(5'd1, 32'd1);
    addi(5'd2, 32'd2);
    addi(5'd1, 32'd2048);
    check("pre_rst_valid", {31'b0, o_valid}, 32'd1);
    check("pre_rst_code", {30'b0, o_err_code}, 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, o_valid}, 32'd0);
    check("arst_code", {30'b0, o_err_code}, 32'd0);
    check("arst_ready", {31'b0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    check("post_rst_err", {31'b0, o_err}, 32'd0);
    check("post_rst_valid", {31'b0, o_valid}, 32'd0);
    addi(5'd3, 32'd3);
    check("post_rst_addr", {24'b0, o_addr}, 32'd0);
    check("post_rst_instr", o_instr, 32'h00300193);
    pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
